// File: rtl/spi_slave_pkg.sv
// ============================================================================
// Module      : spi_slave_pkg
// Description : Shared types and constants for the SPI mode-0 responder:
//               FSM state encoding, SPI clock-edge selection and the default
//               word shifted out when no transmit data is available.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_slave_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_ARM    = 2'd0,  // after reset: wait for SS_N high before joining the bus
    ST_IDLE   = 2'd1,  // deselected, waiting for SS_N falling edge
    ST_ACTIVE = 2'd2   // selected, shifting bits
  } spi_state_e;

  // SPI mode 0: SCLK idles low, data sampled on rising edge, shifted on falling
  localparam logic SPI_CPOL           = 1'b0;
  localparam logic SPI_CPHA           = 1'b0;
  localparam logic SPI_SAMPLE_ON_RISE = (SPI_CPOL == SPI_CPHA);

  // Word driven on MISO when the fabric has nothing to send
  localparam logic [7:0] SPI_IDLE_FILL_DEFAULT = 8'hFF;

endpackage : spi_slave_pkg

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// Module      : spi_sync_edge
// Description : Multi-stage synchroniser for one asynchronous SPI pin followed
//               by one extra flop used for rising/falling edge detection.
// Revision    : 1.0 - initial release
//
// Ports
//   clk_i   in   system clock
//   reset   in   synchronous, active-high reset
//   d_i     in   asynchronous pin input
//   q_o     out  synchronised level
//   rise_o  out  synchronised level went 0 -> 1 (combinational, one cycle)
//   fall_o  out  synchronised level went 1 -> 0 (combinational, one cycle)
// ============================================================================
`default_nettype none

module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // The delay flop resets to the same value as the chain so that reset
  // release never produces a spurious edge.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      dly_q  <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o =  sync_q[SYNC_STAGES-1] & ~dly_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] &  dly_q;

endmodule : spi_sync_edge

`default_nettype wire

// File: rtl/spi_slave_port.sv
// ============================================================================
// Module      : spi_slave_port
// Description : SPI mode-0 responder. Oversamples SCLK/SS_N/MOSI with clk_i,
//               deserialises MSB-first frames into rx_data_o and serialises
//               fabric words onto MISO through a one-entry holding register.
// Revision    : 1.0 - initial release
//
// Ports
//   clk_i          in   system clock
//   reset          in   synchronous, active-high reset
//   spi_sclk_i     in   SPI clock (asynchronous)
//   spi_ss_n_i     in   slave select, active-low (asynchronous)
//   spi_mosi_i     in   master-out data (asynchronous)
//   spi_miso_o     out  slave-out data
//   spi_miso_oe_o  out  MISO pad enable, high while selected
//   rx_data_o      out  last complete received word
//   rx_valid_o     out  one-cycle pulse when rx_data_o updates
//   tx_data_i      in   word for a following frame
//   tx_valid_i     in   TX word offered
//   tx_ready_o     out  holding register empty
//   tx_underrun_o  out  one-cycle pulse when IDLE_FILL is loaded
//   busy_o         out  synchronised SS_N asserted
// ============================================================================
`default_nettype none

module spi_slave_port
  import spi_slave_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_FILL   = DATA_WIDTH'(SPI_IDLE_FILL_DEFAULT)
) (
  input  logic                  clk_i,
  input  logic                  reset,
  input  logic                  spi_sclk_i,
  input  logic                  spi_ss_n_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic                  tx_underrun_o,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  // Cycles after reset before the synchronised SS_N reflects the pin
  localparam logic [ARM_W-1:0] ARM_WAIT = ARM_W'(SYNC_STAGES + 1);

  // --------------------------------------------------------------------------
  // Input synchronisers
  // --------------------------------------------------------------------------
  logic w_sclk_level_unused, w_sclk_rise, w_sclk_fall;
  logic w_ss_n, w_ss_rise, w_ss_fall;
  logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i (clk_i), .reset (reset), .d_i (spi_sclk_i),
    .q_o (w_sclk_level_unused), .rise_o (w_sclk_rise), .fall_o (w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk_i (clk_i), .reset (reset), .d_i (spi_ss_n_i),
    .q_o (w_ss_n), .rise_o (w_ss_rise), .fall_o (w_ss_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i (clk_i), .reset (reset), .d_i (spi_mosi_i),
    .q_o (w_mosi), .rise_o (w_mosi_rise_unused), .fall_o (w_mosi_fall_unused)
  );

  logic w_sample_edge, w_shift_edge;
  assign w_sample_edge = SPI_SAMPLE_ON_RISE ? w_sclk_rise : w_sclk_fall;
  assign w_shift_edge  = SPI_SAMPLE_ON_RISE ? w_sclk_fall : w_sclk_rise;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  spi_state_e            state_q, state_d;
  logic [ARM_W-1:0]      arm_cnt_q, arm_cnt_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  boundary_q, boundary_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                  oe_q, oe_d;
  logic                  underrun_q, underrun_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;

  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_rx_next;

  assign w_rx_next = {rx_shift_q[DATA_WIDTH-2:0], w_mosi};

  always_comb begin
    state_d     = state_q;
    arm_cnt_d   = arm_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    boundary_d  = boundary_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_shift_d  = tx_shift_q;
    oe_d        = oe_q;
    underrun_d  = 1'b0;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    w_load      = 1'b0;

    // Fabric write into the holding register
    if (tx_valid_i && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_data_i;
    end

    case (state_q)
      ST_ARM: begin
        // Let the synchroniser fill with real pin data before trusting SS_N,
        // so a frame already in progress at reset is not joined.
        if (arm_cnt_q != ARM_WAIT) begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end else if (w_ss_n) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (w_ss_fall) begin
          state_d    = ST_ACTIVE;
          bit_cnt_d  = '0;
          boundary_d = 1'b0;
          oe_d       = 1'b1;
          w_load     = 1'b1;
        end
      end

      ST_ACTIVE: begin
        if (w_ss_rise) begin
          // Abort: drop the partial RX word and the current TX word
          state_d    = ST_IDLE;
          bit_cnt_d  = '0;
          boundary_d = 1'b0;
          oe_d       = 1'b0;
          rx_shift_d = '0;
          tx_shift_d = '0;
        end else if (w_sample_edge) begin
          rx_shift_d = w_rx_next;
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d  = w_rx_next;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            boundary_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (w_shift_edge) begin
          if (boundary_q) begin
            w_load     = 1'b1;
            boundary_d = 1'b0;
          end else begin
            tx_shift_d = tx_shift_q << 1;
          end
        end
      end

      default: state_d = ST_ARM;
    endcase

    // Word load: holding register first, then same-cycle bypass, else fill.
    // The bypass overrides the write above so the register stays empty.
    if (w_load) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_data_q;
        hold_full_d = 1'b0;
      end else if (tx_valid_i) begin
        tx_shift_d  = tx_data_i;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = IDLE_FILL;
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q     <= ST_ARM;
      arm_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      boundary_q  <= 1'b0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_shift_q  <= '0;
      oe_q        <= 1'b0;
      underrun_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      arm_cnt_q   <= arm_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      boundary_q  <= boundary_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_shift_q  <= tx_shift_d;
      oe_q        <= oe_d;
      underrun_q  <= underrun_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
    end
  end

  assign spi_miso_o    = tx_shift_q[DATA_WIDTH-1];
  assign spi_miso_oe_o = oe_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_ready_o    = ~hold_full_q;
  assign tx_underrun_o = underrun_q;
  assign busy_o        = ~w_ss_n;

endmodule : spi_slave_port

`default_nettype wire

// File: tb/tb_spi_slave_port.sv
// ============================================================================
// Module      : tb_spi_slave_port
// Description : Self-checking bench for spi_slave_port. A behavioural SPI
//               mode-0 master drives frames; expected RX words and expected
//               MISO words are queued when stimulus is issued and compared
//               when the DUT / master produce them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_slave_port;

  localparam int W     = 8;
  localparam int HALF  = 5;  // SCLK half period in clk cycles
  localparam int SETUP = 6;  // SS_N setup/hold in clk cycles

  logic         clk = 1'b0;
  logic         reset;
  logic         spi_sclk, spi_ss_n, spi_mosi;
  logic         spi_miso_o, spi_miso_oe_o;
  logic [W-1:0] rx_data_o;
  logic         rx_valid_o;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready_o, tx_underrun_o, busy_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int und_cnt      = 0;

  logic [W-1:0] exp_rx_q[$];
  logic [W-1:0] exp_miso_q[$];

  always #5 clk = ~clk;

  spi_slave_port #(.DATA_WIDTH(W), .SYNC_STAGES(2), .IDLE_FILL(8'hFF)) dut (
    .clk_i         (clk),
    .reset         (reset),
    .spi_sclk_i    (spi_sclk),
    .spi_ss_n_i    (spi_ss_n),
    .spi_mosi_i    (spi_mosi),
    .spi_miso_o    (spi_miso_o),
    .spi_miso_oe_o (spi_miso_oe_o),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready_o),
    .tx_underrun_o (tx_underrun_o),
    .busy_o        (busy_o)
  );

  // RX scoreboard and underrun counter, sampled on the falling clock edge
  always @(negedge clk) begin
    if (tx_underrun_o) und_cnt++;
    if (rx_valid_o) begin
      tests_run++;
      if (exp_rx_q.size() == 0) begin
        tests_failed++;
        $display("FAIL rx_unexpected: got rx_valid with rx_data=%02h, required no rx_valid", rx_data_o);
      end else begin
        logic [W-1:0] e;
        e = exp_rx_q.pop_front();
        if (rx_data_o !== e) begin
          tests_failed++;
          $display("FAIL rx_data: got %02h, required %02h", rx_data_o, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ss_assert();
    spi_ss_n = 1'b0;
    wait_clks(SETUP);
  endtask

  task automatic ss_release();
    wait_clks(SETUP);
    spi_ss_n = 1'b1;
    wait_clks(SETUP + 2);
  endtask

  // Shift nbits MSB-first; optionally offer a TX word while bit 4 is low.
  task automatic xfer_bits(input logic [W-1:0] mo, input int nbits,
                           input bit offer, input logic [W-1:0] offer_data,
                           output logic [W-1:0] mi);
    mi = '0;
    for (int i = W - 1; i >= W - nbits; i--) begin
      spi_mosi = mo[i];
      if (offer && i == 4) begin
        tx_data  = offer_data;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_clks(HALF - 1);
      end else begin
        wait_clks(HALF);
      end
      mi[i]    = spi_miso_o;
      spi_sclk = 1'b1;
      wait_clks(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic write_hold(input logic [W-1:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // ------------------------------------------------------------------- tests
  task automatic test_reset();
    reset = 1'b1; spi_ss_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    wait_clks(3);
    tests_run++; if (spi_miso_o !== 1'b0) begin tests_failed++; $display("FAIL reset_miso: got %b, required 0", spi_miso_o); end
    tests_run++; if (spi_miso_oe_o !== 1'b0) begin tests_failed++; $display("FAIL reset_oe: got %b, required 0", spi_miso_oe_o); end
    tests_run++; if (rx_data_o !== 8'h00) begin tests_failed++; $display("FAIL reset_rx_data: got %02h, required 00", rx_data_o); end
    tests_run++; if (tx_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_tx_ready: got %b, required 1", tx_ready_o); end
    tests_run++; if (tx_underrun_o !== 1'b0) begin tests_failed++; $display("FAIL reset_underrun: got %b, required 0", tx_underrun_o); end
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", busy_o); end
    reset = 1'b0;
    wait_clks(8);
  endtask

  task automatic test_preload_frame();
    logic [W-1:0] mi, e;
    write_hold(8'hA5);
    tests_run++; if (tx_ready_o !== 1'b0) begin tests_failed++; $display("FAIL preload_ready_low: got %b, required 0", tx_ready_o); end
    exp_rx_q.push_back(8'h3C);
    exp_miso_q.push_back(8'hA5);
    ss_assert();
    tests_run++; if (spi_miso_oe_o !== 1'b1) begin tests_failed++; $display("FAIL preload_oe: got %b, required 1", spi_miso_oe_o); end
    tests_run++; if (tx_ready_o !== 1'b1) begin tests_failed++; $display("FAIL preload_ready_after_load: got %b, required 1", tx_ready_o); end
    tests_run++; if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL preload_busy: got %b, required 1", busy_o); end
    xfer_bits(8'h3C, W, 1'b0, '0, mi);
    e = exp_miso_q.pop_front();
    tests_run++; if (mi !== e) begin tests_failed++; $display("FAIL preload_miso: got %02h, required %02h", mi, e); end
    ss_release();
    tests_run++; if (spi_miso_oe_o !== 1'b0) begin tests_failed++; $display("FAIL preload_oe_off: got %b, required 0", spi_miso_oe_o); end
    tests_run++; if (exp_rx_q.size() != 0) begin tests_failed++; $display("FAIL preload_rx_missing: got %0d pending, required 0", exp_rx_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] mi, e;
    write_hold(8'h01);
    und_cnt = 0;
    exp_rx_q.push_back(8'hF0); exp_rx_q.push_back(8'h0F); exp_rx_q.push_back(8'h55);
    exp_miso_q.push_back(8'h01); exp_miso_q.push_back(8'h02); exp_miso_q.push_back(8'h03);
    ss_assert();
    xfer_bits(8'hF0, W, 1'b1, 8'h02, mi);
    e = exp_miso_q.pop_front();
    tests_run++; if (mi !== e) begin tests_failed++; $display("FAIL burst_miso0: got %02h, required %02h", mi, e); end
    xfer_bits(8'h0F, W, 1'b1, 8'h03, mi);
    e = exp_miso_q.pop_front();
    tests_run++; if (mi !== e) begin tests_failed++; $display("FAIL burst_miso1: got %02h, required %02h", mi, e); end
    xfer_bits(8'h55, W, 1'b0, '0, mi);
    e = exp_miso_q.pop_front();
    tests_run++; if (mi !== e) begin tests_failed++; $display("FAIL burst_miso2: got %02h, required %02h", mi, e); end
    tests_run++; if (und_cnt != 0) begin tests_failed++; $display("FAIL burst_underrun: got %0d pulses, required 0", und_cnt); end
    ss_release();
    tests_run++; if (exp_rx_q.size() != 0) begin tests_failed++; $display("FAIL burst_rx_missing: got %0d pending, required 0", exp_rx_q.size()); end
  endtask

  task automatic test_underrun();
    logic [W-1:0] mi, e;
    tests_run++; if (tx_ready_o !== 1'b1) begin tests_failed++; $display("FAIL underrun_ready: got %b, required 1", tx_ready_o); end
    und_cnt = 0;
    exp_rx_q.push_back(8'h96);
    exp_miso_q.push_back(8'hFF);
    ss_assert();
    tests_run++; if (und_cnt != 1) begin tests_failed++; $display("FAIL underrun_start: got %0d pulses, required 1", und_cnt); end
    xfer_bits(8'h96, W, 1'b0, '0, mi);
    e = exp_miso_q.pop_front();
    tests_run++; if (mi !== e) begin tests_failed++; $display("FAIL underrun_miso: got %02h, required %02h", mi, e); end
    tests_run++; if (und_cnt != 1) begin tests_failed++; $display("FAIL underrun_once: got %0d pulses, required 1", und_cnt); end
    ss_release();
  endtask

  task automatic test_bypass();
    logic [W-1:0] mi, e;
    und_cnt = 0;
    exp_rx_q.push_back(8'h3A);
    exp_miso_q.push_back(8'hC3);
    // Frame-start load happens on the 3rd rising clk edge after SS_N falls
    spi_ss_n = 1'b0;
    wait_clks(2);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (tx_ready_o !== 1'b1) begin tests_failed++; $display("FAIL bypass_ready: got %b, required 1", tx_ready_o); end
    tests_run++; if (und_cnt != 0) begin tests_failed++; $display("FAIL bypass_underrun: got %0d pulses, required 0", und_cnt); end
    wait_clks(SETUP - 4);
    xfer_bits(8'h3A, W, 1'b0, '0, mi);
    e = exp_miso_q.pop_front();
    tests_run++; if (mi !== e) begin tests_failed++; $display("FAIL bypass_miso: got %02h, required %02h", mi, e); end
    ss_release();
  endtask

  task automatic test_abort();
    logic [W-1:0] mi, e;
    ss_assert();
    // Offer a word mid-frame; it must survive the abort
    xfer_bits(8'hB7, 5, 1'b1, 8'h77, mi);
    ss_release();
    tests_run++; if (spi_miso_oe_o !== 1'b0) begin tests_failed++; $display("FAIL abort_oe: got %b, required 0", spi_miso_oe_o); end
    tests_run++; if (rx_data_o !== 8'h3A) begin tests_failed++; $display("FAIL abort_rx_hold: got %02h, required 3A", rx_data_o); end
    tests_run++; if (tx_ready_o !== 1'b0) begin tests_failed++; $display("FAIL abort_hold_kept: got ready=%b, required 0", tx_ready_o); end
    exp_rx_q.push_back(8'h81);
    exp_miso_q.push_back(8'h77);
    ss_assert();
    xfer_bits(8'h81, W, 1'b0, '0, mi);
    e = exp_miso_q.pop_front();
    tests_run++; if (mi !== e) begin tests_failed++; $display("FAIL abort_next_miso: got %02h, required %02h", mi, e); end
    ss_release();
    tests_run++; if (exp_rx_q.size() != 0) begin tests_failed++; $display("FAIL abort_next_rx: got %0d pending, required 0", exp_rx_q.size()); end
  endtask

  task automatic test_reset_midframe();
    logic [W-1:0] mi, e;
    ss_assert();
    xfer_bits(8'hE6, 3, 1'b0, '0, mi);
    reset = 1'b1;
    wait_clks(2);
    reset = 1'b0;
    tests_run++; if (rx_data_o !== 8'h00) begin tests_failed++; $display("FAIL rstmid_rx_data: got %02h, required 00", rx_data_o); end
    tests_run++; if (spi_miso_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_miso: got %b, required 0", spi_miso_o); end
    // SS_N still low: a full byte of SCLK must be ignored
    xfer_bits(8'hC9, W, 1'b0, '0, mi);
    tests_run++; if (spi_miso_oe_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_oe_armed: got %b, required 0", spi_miso_oe_o); end
    ss_release();
    exp_rx_q.push_back(8'h5A);
    exp_miso_q.push_back(8'hFF);
    ss_assert();
    xfer_bits(8'h5A, W, 1'b0, '0, mi);
    e = exp_miso_q.pop_front();
    tests_run++; if (mi !== e) begin tests_failed++; $display("FAIL rstmid_next_miso: got %02h, required %02h", mi, e); end
    ss_release();
    tests_run++; if (rx_data_o !== 8'h5A) begin tests_failed++; $display("FAIL rstmid_next_rx: got %02h, required 5A", rx_data_o); end
    tests_run++; if (exp_rx_q.size() != 0) begin tests_failed++; $display("FAIL rstmid_rx_missing: got %0d pending, required 0", exp_rx_q.size()); end
  endtask

  initial begin
    test_reset();
    test_preload_frame();
    test_back_to_back();
    test_underrun();
    test_bypass();
    test_abort();
    test_reset_midframe();
    wait_clks(4);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_spi_slave_port

`default_nettype wire
